// File: rtl/cpu_control_unit.sv
// Hardwired fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Drives the shared datapath control bus and supervises memory handshakes.
module cpu_control_unit #(
    parameter int OPC_W    = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPC_W-1:0] opcode,
    input  logic             acc_neg,
    input  logic             mem_ready,
    output logic [31:0]      control_signal,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [OPC_W-1:0] OP_NOP    = OPC_W'(8'h00);
    localparam logic [OPC_W-1:0] OP_STORE  = OPC_W'(8'h01);
    localparam logic [OPC_W-1:0] OP_LOAD   = OPC_W'(8'h02);
    localparam logic [OPC_W-1:0] OP_ADD    = OPC_W'(8'h03);
    localparam logic [OPC_W-1:0] OP_SUB    = OPC_W'(8'h04);
    localparam logic [OPC_W-1:0] OP_JMPGEZ = OPC_W'(8'h05);
    localparam logic [OPC_W-1:0] OP_JMP    = OPC_W'(8'h06);
    localparam logic [OPC_W-1:0] OP_HALT   = OPC_W'(8'h07);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_F0   = 3'd1,
        S_F1   = 3'd2,
        S_F2   = 3'd3,
        S_E1   = 3'd4,
        S_E2   = 3'd5,
        S_E3   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               fault_q, fault_d;
    logic [31:0]        ctrl_d;
    logic               waiting;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        fault_d = fault_q;
        ctrl_d  = '0;
        waiting = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_F0;
            end
            S_F0: begin
                ctrl_d[2] = 1'b1;
                state_d   = S_F1;
            end
            S_F1: begin
                ctrl_d[10] = 1'b1;
                ctrl_d[17] = 1'b1;
                // PC advances only in the cycle the fetch actually completes
                if (mem_ready) begin
                    ctrl_d[0] = 1'b1;
                    state_d   = S_F2;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_F2: begin
                ctrl_d[4] = 1'b1;
                ctrl_d[3] = 1'b1;
                state_d   = S_E1;
            end
            S_E1: begin
                case (opcode)
                    OP_NOP:   state_d = S_F0;
                    OP_STORE: begin
                        ctrl_d[19] = 1'b1;
                        state_d    = S_E2;
                    end
                    OP_LOAD, OP_ADD, OP_SUB: begin
                        ctrl_d[10] = 1'b1;
                        ctrl_d[17] = 1'b1;
                        if (mem_ready) state_d = S_E2;
                        else           waiting = 1'b1;
                    end
                    OP_JMPGEZ: begin
                        ctrl_d[1] = ~acc_neg;
                        state_d   = S_F0;
                    end
                    OP_JMP: begin
                        ctrl_d[1] = 1'b1;
                        state_d   = S_F0;
                    end
                    OP_HALT:  state_d = S_HALT;
                    default: begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_E2: begin
                if (opcode == OP_STORE) begin
                    ctrl_d[11] = 1'b1;
                    if (mem_ready) state_d = S_F0;
                    else           waiting = 1'b1;
                end else begin
                    ctrl_d[5] = 1'b1;
                    state_d   = S_E3;
                end
            end
            S_E3: begin
                case (opcode)
                    OP_LOAD: ctrl_d[9] = 1'b1;
                    OP_ADD:  ctrl_d[7] = 1'b1;
                    OP_SUB:  ctrl_d[8] = 1'b1;
                    default: ctrl_d    = '0;
                endcase
                state_d = S_F0;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // The MAX_WAIT-th consecutive stall cycle without a handshake is a timeout
        if (waiting) begin
            if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                fault_d = 1'b1;
                state_d = S_HALT;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end
    end

    assign control_signal = ctrl_d;
    assign state          = state_q;
    assign halted         = (state_q == S_HALT);
    assign fault          = fault_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Randomized scoreboard bench for cpu_control_unit: an instruction-level model
// expands each instruction into its expected per-cycle bus activity.
module tb_cpu_control_unit;

    localparam int MAXW = 15;

    typedef struct {
        logic [2:0]  st;
        logic [31:0] ctrl;
        logic        rdy;
        logic        strt;
        logic [7:0]  opc;
        logic        accn;
        logic        hlt;
        logic        flt;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  opcode = 8'h00;
    logic        acc_neg = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] control_signal;
    logic [2:0]  state;
    logic        halted;
    logic        fault;

    cyc_t plan[$];
    cyc_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic fltM = 1'b0;

    cpu_control_unit #(.OPC_W(8), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .acc_neg(acc_neg), .mem_ready(mem_ready),
        .control_signal(control_signal), .state(state),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] rop();
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic addCyc(input logic [2:0] st, input logic [31:0] ctrl, input logic rdy,
                          input logic strt, input logic [7:0] opc, input logic accn);
        cyc_t c;
        c.st = st; c.ctrl = ctrl; c.rdy = rdy; c.strt = strt;
        c.opc = opc; c.accn = accn; c.hlt = (st == 3'd7); c.flt = fltM;
        plan.push_back(c);
    endtask

    task automatic addHalt(input int n);
        for (int i = 0; i < n; i++) addCyc(3'd7, 32'h0, rb(), rb(), rop(), rb());
    endtask

    task automatic addIdle(input int n, input bit go);
        for (int i = 0; i < n; i++) addCyc(3'd0, 32'h0, rb(), 1'b0, rop(), rb());
        if (go) addCyc(3'd0, 32'h0, rb(), 1'b1, rop(), rb());
    endtask

    // Expands one instruction into expected cycles; stall counts of MAXW or more time out
    task automatic planInstr(input logic [7:0] opc, input logic accn, input int sF1,
                             input int sE, output bit stopped);
        stopped = 1'b0;
        addCyc(3'd1, 32'h4, rb(), rb(), rop(), rb());
        for (int i = 0; i < sF1 && i < MAXW; i++) addCyc(3'd2, 32'h20400, 1'b0, rb(), rop(), rb());
        if (sF1 >= MAXW) begin fltM = 1'b1; addHalt(3); stopped = 1'b1; return; end
        addCyc(3'd2, 32'h20401, 1'b1, rb(), rop(), rb());
        addCyc(3'd3, 32'h18, rb(), rb(), opc, rb());
        case (opc)
            8'h00: addCyc(3'd4, 32'h0, rb(), rb(), opc, rb());
            8'h01: begin
                addCyc(3'd4, 32'h80000, rb(), rb(), opc, rb());
                for (int i = 0; i < sE && i < MAXW; i++) addCyc(3'd5, 32'h800, 1'b0, rb(), opc, rb());
                if (sE >= MAXW) begin fltM = 1'b1; addHalt(3); stopped = 1'b1; return; end
                addCyc(3'd5, 32'h800, 1'b1, rb(), opc, rb());
            end
            8'h02, 8'h03, 8'h04: begin
                for (int i = 0; i < sE && i < MAXW; i++) addCyc(3'd4, 32'h20400, 1'b0, rb(), opc, rb());
                if (sE >= MAXW) begin fltM = 1'b1; addHalt(3); stopped = 1'b1; return; end
                addCyc(3'd4, 32'h20400, 1'b1, rb(), opc, rb());
                addCyc(3'd5, 32'h20, rb(), rb(), opc, rb());
                addCyc(3'd6, (opc == 8'h02) ? 32'h200 : (opc == 8'h03) ? 32'h80 : 32'h100,
                       rb(), rb(), opc, rb());
            end
            8'h05: addCyc(3'd4, accn ? 32'h0 : 32'h2, rb(), rb(), opc, accn);
            8'h06: addCyc(3'd4, 32'h2, rb(), rb(), opc, rb());
            8'h07: begin
                addCyc(3'd4, 32'h0, rb(), rb(), opc, rb());
                addHalt(3); stopped = 1'b1;
            end
            default: begin
                addCyc(3'd4, 32'h0, rb(), rb(), opc, rb());
                fltM = 1'b1; addHalt(3); stopped = 1'b1;
            end
        endcase
    endtask

    task automatic checkOutput(input cyc_t e, input string name);
        checks++;
        if (state !== e.st || control_signal !== e.ctrl || halted !== e.hlt || fault !== e.flt) begin
            errors++;
            $display("[TB] FAIL %s t=%0t: got state=%0d ctrl=%h halted=%b fault=%b, expected state=%0d ctrl=%h halted=%b fault=%b",
                     name, $time, state, control_signal, halted, fault, e.st, e.ctrl, e.hlt, e.flt);
        end
    endtask

    // Plays the planned cycles onto the inputs; optionally asserts rst mid-cycle at the end
    task automatic applyStimulus(input bit rstAtEnd);
        cyc_t c;
        cyc_t z;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            @(negedge clk);
            start = c.strt; opcode = c.opc; acc_neg = c.accn; mem_ready = c.rdy;
            sbq.push_back(c);
        end
        if (rstAtEnd) begin
            #3 rst = 1'b1;
            #1;
            z.st = 3'd0; z.ctrl = 32'h0; z.hlt = 1'b0; z.flt = 1'b0;
            checkOutput(z, "async_reset");
            fltM = 1'b0;
        end
    endtask

    task automatic doReset();
        cyc_t z;
        @(negedge clk);
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        z.st = 3'd0; z.ctrl = 32'h0; z.hlt = 1'b0; z.flt = 1'b0;
        checkOutput(z, "reset_state");
        rst = 1'b0;
        fltM = 1'b0;
    endtask

    initial begin : monitor
        cyc_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput(e, "cycle");
            end
        end
    end

    initial begin : main
        bit stopped;
        logic [7:0] op;
        int r;

        doReset();
        addIdle(10, 1'b1);
        planInstr(8'h02, rb(), 0, 0, stopped);
        planInstr(8'h01, rb(), 0, 3, stopped);
        planInstr(8'h05, 1'b0, 0, 0, stopped);
        planInstr(8'h05, 1'b1, 0, 0, stopped);
        planInstr(8'h06, rb(), 1, 0, stopped);
        planInstr(8'h00, rb(), 0, 0, stopped);
        planInstr(8'h03, rb(), 2, 14, stopped);
        planInstr(8'h04, rb(), 14, 1, stopped);
        planInstr(8'h3C, rb(), 0, 0, stopped);
        applyStimulus(1'b0);
        doReset();

        addIdle(2, 1'b1);
        planInstr(8'h02, rb(), 0, 0, stopped);
        applyStimulus(1'b1);
        doReset();

        addIdle(1, 1'b1);
        planInstr(8'h00, 1'b0, MAXW, 0, stopped);
        applyStimulus(1'b0);
        doReset();

        addIdle(1, 1'b1);
        planInstr(8'h01, 1'b0, 0, MAXW, stopped);
        applyStimulus(1'b0);
        doReset();

        for (int s = 0; s < 8; s++) begin
            addIdle($urandom_range(0, 2), 1'b1);
            for (int k = 0; k < 12; k++) begin
                r = $urandom_range(0, 99);
                if (r < 85)      op = 8'($urandom_range(0, 6));
                else if (r < 92) op = 8'h07;
                else             op = 8'($urandom_range(8, 255));
                planInstr(op, rb(),
                          ($urandom_range(0, 29) == 0) ? MAXW : $urandom_range(0, 3),
                          ($urandom_range(0, 29) == 0) ? MAXW : $urandom_range(0, 3),
                          stopped);
                if (stopped) break;
            end
            applyStimulus(1'b0);
            doReset();
        end

        for (int w = 0; w < 10 && sbq.size() > 0; w++) @(negedge clk);
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", sbq.size());
        end
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
